// File: rtl/reg_lut_reg_pipe.sv
// Register -> reduction LUT -> register pipeline with per-sample op select, valid tracking,
// a global stall and a saturating counter of true results.
module reg_lut_reg_pipe #(
    parameter int unsigned N_IN       = 6,
    parameter int unsigned IN_STAGES  = 2,
    parameter int unsigned OUT_STAGES = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clock0,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_data,
    input  logic [1:0]       op_sel,
    input  logic             clear_count,
    output logic             out_valid,
    output logic             red_output,
    output logic [CNT_W-1:0] hit_count
);

    logic [IN_STAGES-1:0][N_IN-1:0] data_q, data_d;
    logic [IN_STAGES-1:0][1:0]      op_q, op_d;
    logic [IN_STAGES-1:0]           ivld_q, ivld_d;
    logic [OUT_STAGES-1:0]          res_q, res_d;
    logic [OUT_STAGES-1:0]          ovld_q, ovld_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [N_IN-1:0]                red_in;
    logic                           red_d;

    // Input stages: data, op_sel and valid travel together so each sample keeps its own op.
    assign data_d[0] = in_data;
    assign op_d[0]   = op_sel;
    assign ivld_d[0] = in_valid;
    for (genvar s = 1; s < IN_STAGES; s++) begin : g_in_shift
        assign data_d[s] = data_q[s-1];
        assign op_d[s]   = op_q[s-1];
        assign ivld_d[s] = ivld_q[s-1];
    end

    assign red_in = data_q[IN_STAGES-1];

    always_comb begin
        red_d = 1'b0;
        if (ivld_q[IN_STAGES-1]) begin
            case (op_q[IN_STAGES-1])
                2'b00:   red_d = &red_in;
                2'b01:   red_d = |red_in;
                2'b10:   red_d = ^red_in;
                default: red_d = ~&red_in;
            endcase
        end
    end

    // Output stages are pure delay; no logic between them.
    assign res_d[0]  = red_d;
    assign ovld_d[0] = ivld_q[IN_STAGES-1];
    for (genvar s = 1; s < OUT_STAGES; s++) begin : g_out_shift
        assign res_d[s]  = res_q[s-1];
        assign ovld_d[s] = ovld_q[s-1];
    end

    // Count on the edge that loads a valid true result into the final stage.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_count) begin
            cnt_d = '0;
        end else if (enable && ovld_d[OUT_STAGES-1] && res_d[OUT_STAGES-1] && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            op_q   <= '0;
            ivld_q <= '0;
            res_q  <= '0;
            ovld_q <= '0;
        end else if (enable) begin
            data_q <= data_d;
            op_q   <= op_d;
            ivld_q <= ivld_d;
            res_q  <= res_d;
            ovld_q <= ovld_d;
        end
    end

    always_ff @(posedge clock0 or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_valid  = ovld_q[OUT_STAGES-1];
    assign red_output = res_q[OUT_STAGES-1];
    assign hit_count  = cnt_q;

endmodule

// File: tb/tb_reg_lut_reg_pipe.sv
// Scoreboard bench for reg_lut_reg_pipe: directed vectors push hand-computed results, a monitor
// pops and checks value and arrival edge whenever a new valid output is presented.
module tb_reg_lut_reg_pipe;

    localparam int unsigned N_IN  = 6;
    localparam int unsigned CNT_W = 8;

    logic             clock0      = 1'b0;
    logic             reset       = 1'b1;
    logic             enable      = 1'b0;
    logic             in_valid    = 1'b0;
    logic [N_IN-1:0]  in_data     = '0;
    logic [1:0]       op_sel      = '0;
    logic             clear_count = 1'b0;
    logic             out_valid;
    logic             red_output;
    logic [CNT_W-1:0] hit_count;

    reg_lut_reg_pipe #(
        .N_IN      (N_IN),
        .IN_STAGES (2),
        .OUT_STAGES(2),
        .CNT_W     (CNT_W)
    ) dut (
        .clock0     (clock0),
        .reset      (reset),
        .enable     (enable),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .op_sel     (op_sel),
        .clear_count(clear_count),
        .out_valid  (out_valid),
        .red_output (red_output),
        .hit_count  (hit_count)
    );

    always #5 clock0 = ~clock0;

    typedef struct packed {
        logic        red;
        int unsigned due;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_cmp    = 0;
    int unsigned n_bad    = 0;
    int unsigned en_edges = 0;
    logic        last_en  = 1'b0;
    logic        last_red = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clock0) begin
        last_en <= enable && !reset;
        if (enable && !reset) en_edges <= en_edges + 1;
    end

    // Monitor: a new output only appears after an enabled edge; otherwise it must hold.
    always @(negedge clock0) begin
        exp_t e;
        if (!reset) begin
            if (out_valid) begin
                if (last_en) begin
                    check("sb_nonempty", sb_q.size() != 0, 1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check("red_output", red_output, e.red);
                        check("latency_edge", en_edges, e.due);
                        last_red <= e.red;
                    end
                end else begin
                    check("held_output", red_output, last_red);
                end
            end else begin
                check("idle_red_zero", red_output, 0);
            end
        end
    end

    task automatic drive(input logic v, input logic [N_IN-1:0] d, input logic [1:0] op,
                         input logic en, input logic exp_red);
        exp_t e;
        @(negedge clock0);
        enable   = en;
        in_valid = v;
        in_data  = d;
        op_sel   = op;
        if (en && v) begin
            e.red = exp_red;
            e.due = en_edges + 4;
            sb_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 2'b00, 1'b1, 1'b0);
    endtask

    task automatic stall(input int n);
        repeat (n) drive(1'b1, 6'h3F, 2'b00, 1'b0, 1'b1);
    endtask

    task automatic clr();
        @(negedge clock0);
        enable      = 1'b1;
        in_valid    = 1'b0;
        clear_count = 1'b1;
        @(negedge clock0);
        clear_count = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clock0);
        check("rst_out_valid", out_valid, 0);
        check("rst_red_output", red_output, 0);
        check("rst_hit_count", hit_count, 0);
        reset = 1'b0;

        // AND of all ones
        drive(1'b1, 6'h3F, 2'b00, 1'b1, 1'b1);
        idle(5);
        check("hit_and_ones", hit_count, 1);
        clr();
        check("hit_after_clear", hit_count, 0);

        // Mixed ops back-to-back
        drive(1'b1, 6'h3F, 2'b00, 1'b1, 1'b1);
        drive(1'b1, 6'h00, 2'b01, 1'b1, 1'b0);
        drive(1'b1, 6'h15, 2'b10, 1'b1, 1'b1);
        drive(1'b1, 6'h3F, 2'b11, 1'b1, 1'b0);
        idle(6);
        check("hit_mixed", hit_count, 2);
        drive(1'b1, 6'h2A, 2'b01, 1'b1, 1'b1);
        drive(1'b1, 6'h3F, 2'b10, 1'b1, 1'b0);
        drive(1'b1, 6'h00, 2'b11, 1'b1, 1'b1);
        drive(1'b1, 6'h07, 2'b00, 1'b1, 1'b0);
        drive(1'b1, 6'h00, 2'b00, 1'b1, 1'b0);
        drive(1'b1, 6'h3E, 2'b00, 1'b1, 1'b0);
        drive(1'b1, 6'h01, 2'b10, 1'b1, 1'b1);
        drive(1'b1, 6'h3F, 2'b01, 1'b1, 1'b1);
        idle(6);
        check("hit_mixed2", hit_count, 6);

        // Stall with two samples in flight, then again with one at the output
        clr();
        drive(1'b1, 6'h3F, 2'b00, 1'b1, 1'b1);
        drive(1'b1, 6'h3F, 2'b01, 1'b1, 1'b1);
        stall(3);
        idle(2);
        stall(2);
        idle(5);
        check("hit_stall", hit_count, 2);

        // Bubbles
        clr();
        for (int i = 0; i < 6; i++) drive((i % 2) == 0, 6'h3F, 2'b00, 1'b1, 1'b1);
        idle(6);
        check("hit_bubbles", hit_count, 3);

        // Saturation
        clr();
        repeat (300) drive(1'b1, 6'h3F, 2'b00, 1'b1, 1'b1);
        idle(6);
        check("hit_saturated", hit_count, 8'hFF);
        clr();
        check("hit_sat_clear", hit_count, 0);

        // Clear on the same edge as an increment
        drive(1'b1, 6'h3F, 2'b00, 1'b1, 1'b1);
        idle(2);
        clr();
        check("hit_clear_prio", hit_count, 0);
        idle(3);
        check("hit_clear_prio_hold", hit_count, 0);

        // Async reset mid-stream
        drive(1'b1, 6'h3F, 2'b00, 1'b1, 1'b1);
        drive(1'b1, 6'h3F, 2'b01, 1'b1, 1'b1);
        drive(1'b1, 6'h15, 2'b10, 1'b1, 1'b1);
        idle(1);
        @(negedge clock0);
        check("pre_rst_hit", hit_count, 1);
        #2 reset = 1'b1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_red_output", red_output, 0);
        check("async_hit_count", hit_count, 0);
        sb_q.delete();
        @(negedge clock0);
        reset = 1'b0;
        idle(8);
        check("post_rst_hit", hit_count, 0);
        drive(1'b1, 6'h01, 2'b01, 1'b1, 1'b1);
        idle(6);
        check("post_rst_hit_new", hit_count, 1);

        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
